// File: rtl/duoseg_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment scanner.
package duoseg_pkg;
  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [1:0] DIG_OFF = 2'b11;
endpackage

// File: rtl/duoseg_slot_timer.sv
// Per-digit slot counter: dead-time phase at the start of each slot, wrap at slot end.
module duoseg_slot_timer #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic blank_phase,
  output logic blank_last,
  output logic slot_end
);
  localparam int CW = $clog2(SLOT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  assign blank_phase = cnt_q < CW'(BLANK_CYCLES);
  assign blank_last  = cnt_q == CW'(BLANK_CYCLES - 1);
  assign slot_end    = cnt_q == CW'(SLOT_CYCLES - 1);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || slot_end) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
endmodule

// File: rtl/duoseg_scanner.sv
// Two-digit 7-segment scanner with per-slot dead time and frame-coherent shadow.
// Optional PWM dimming on the digit enables with macro DUOSEG_SCAN_DIM_EN.
module duoseg_scanner
  import duoseg_pkg::*;
#(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [13:0] seg_data,
  output logic [6:0]  seg_n,
  output logic [1:0]  dig_n,
  output logic        frame_tick
`ifdef DUOSEG_SCAN_DIM_EN
  ,
  input  logic [3:0]  bright
`endif
);
  scan_state_t state_q, state_d;
  logic [13:0] shadow_q, shadow_d;
  logic [6:0]  seg_q, seg_d;
  logic [1:0]  dig_q, dig_d;
  logic        tick_q, tick_d;
  logic        blank_phase, blank_last, slot_end;
  logic        show, dig_on;

  duoseg_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (!en),
    .blank_phase(blank_phase),
    .blank_last (blank_last),
    .slot_end   (slot_end)
  );

`ifdef DUOSEG_SCAN_DIM_EN
  logic [3:0] pwm_q, pwm_d;
  assign pwm_d  = pwm_q + 4'd1;
  assign dig_on = (bright == 4'hF) || (pwm_q < bright);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pwm_q <= '0;
    else          pwm_q <= pwm_d;
`else
  assign dig_on = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BLANK0: if (blank_last) state_d = SHOW0;
      SHOW0:  if (slot_end)   state_d = BLANK1;
      BLANK1: if (blank_last) state_d = SHOW1;
      SHOW1:  if (slot_end)   state_d = BLANK0;
      default:                state_d = BLANK0;
    endcase
    if (!en) state_d = BLANK0;
  end

  // Shadow only follows seg_data while parked in BLANK0, so a frame is never torn.
  assign shadow_d = (state_q == BLANK0 || !en) ? seg_data : shadow_q;
  assign show     = en && !blank_phase && (state_q == SHOW0 || state_q == SHOW1);

  always_comb begin
    seg_d  = SEG_OFF;
    dig_d  = DIG_OFF;
    tick_d = en && (state_q == SHOW1) && slot_end;
    if (show) begin
      if (state_q == SHOW0) begin
        seg_d = ~shadow_q[6:0];
        dig_d = dig_on ? 2'b10 : DIG_OFF;
      end else begin
        seg_d = ~shadow_q[13:7];
        dig_d = dig_on ? 2'b01 : DIG_OFF;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= BLANK0;
      shadow_q <= '0;
      seg_q    <= SEG_OFF;
      dig_q    <= DIG_OFF;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      tick_q   <= tick_d;
    end

  assign seg_n      = seg_q;
  assign dig_n      = dig_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_duoseg_scanner.sv
// Directed bench for duoseg_scanner with SLOT_CYCLES=8, BLANK_CYCLES=2 (16-cycle frame).
module tb_duoseg_scanner;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [13:0] seg_data;
  logic [6:0]  seg_n;
  logic [1:0]  dig_n;
  logic        frame_tick;
  logic        both_low = 1'b0;
  int          checks = 0;
  int          failures = 0;
`ifdef DUOSEG_SCAN_DIM_EN
  logic [3:0]  bright = 4'hF;
  int          on_cnt;
`endif

  duoseg_scanner #(.SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .seg_data  (seg_data),
    .seg_n     (seg_n),
    .dig_n     (dig_n),
    .frame_tick(frame_tick)
`ifdef DUOSEG_SCAN_DIM_EN
    ,
    .bright    (bright)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dig_n === 2'b00) both_low = 1'b1;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts aligned to a BLANK0 cycle with cnt=0; k counts edges into the frame.
  task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic mid_en, input logic [13:0] mid_val);
    logic [6:0] es;
    logic [1:0] ed;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (mid_en && k == 4) seg_data = mid_val;
      es = 7'h7F; ed = 2'b11;
      if (k >= 3 && k <= 8)   begin es = s0; ed = 2'b10; end
      if (k >= 11 && k <= 16) begin es = s1; ed = 2'b01; end
      chk($sformatf("%s_k%0d", tag, k), {seg_n, dig_n, frame_tick}, {es, ed, (k == 16)});
    end
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; seg_data = 14'h0000;
    #12;
    chk("reset_out", {seg_n, dig_n, frame_tick}, {7'h7F, 2'b11, 1'b0});
    @(negedge clk) reset_n = 1'b1;

    check_frame("zero", 7'h7F, 7'h7F, 1'b0, 14'h0);
    seg_data = {7'h7F, 7'h06};
    check_frame("pat", 7'h79, 7'h00, 1'b0, 14'h0);
    seg_data = 14'h0001;
    check_frame("tear_cur", 7'h7E, 7'h7F, 1'b1, 14'h0002);
    check_frame("tear_nxt", 7'h7D, 7'h7F, 1'b0, 14'h0);

    for (int k = 1; k <= 12; k++) step();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("en_low%0d", k), {seg_n, dig_n, frame_tick}, {7'h7F, 2'b11, 1'b0});
    end
    en = 1'b1;
    check_frame("en_restart", 7'h7D, 7'h7F, 1'b0, 14'h0);

    for (int k = 1; k <= 5; k++) step();
    chk("pre_rst_show", {seg_n, dig_n, frame_tick}, {7'h7D, 2'b10, 1'b0});
    #2 reset_n = 1'b0;
    #1 chk("async_rst", {seg_n, dig_n, frame_tick}, {7'h7F, 2'b11, 1'b0});
    @(negedge clk) reset_n = 1'b1;
    check_frame("post_rst", 7'h7D, 7'h7F, 1'b0, 14'h0);

`ifdef DUOSEG_SCAN_DIM_EN
    bright = 4'h0; on_cnt = 0;
    for (int k = 1; k <= 16; k++) begin step(); if (dig_n != 2'b11) on_cnt++; end
    chk("dim_b0", 10'(on_cnt), 10'd0);
    bright = 4'hF; on_cnt = 0;
    for (int k = 1; k <= 16; k++) begin step(); if (dig_n != 2'b11) on_cnt++; end
    chk("dim_bF", 10'(on_cnt), 10'd12);
    bright = 4'h4; on_cnt = 0;
    for (int k = 1; k <= 16; k++) begin step(); if (dig_n != 2'b11) on_cnt++; end
    chk("dim_b4", {9'd0, (on_cnt >= 2 && on_cnt <= 4)}, 10'd1);
    bright = 4'hF;
`endif

    chk("never_both_low", {9'd0, both_low}, 10'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
